// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: shared types and constants for the reaction-game blocks.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: rg_state_t round state enum, LFSR_TAPS feedback mask, default LFSR_SEED.
package reaction_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_RESULT = 2'd3
  } rg_state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/reaction_game_lfsr.sv
// reaction_game_lfsr: 16-bit Fibonacci LFSR, free-running while i_en is high.
// Latency: new value one cycle after each enabled edge. Backpressure: none.
// Ports: clk, reset (sync, active-high, reloads SEED), i_en, o_lfsr[15:0].
module reaction_game_lfsr
  import reaction_game_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // An all-zero seed locks the register at zero forever.
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("reaction_game_lfsr: SEED must be nonzero");
  end

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/reaction_game_timer_fsm.sv
// reaction_game_timer_fsm: reaction-time game round controller on a 1 ms tick base.
// Latency: all outputs registered, one cycle after the causing input. Backpressure: none;
// start is ignored while busy, tick assumed >= 2 cycles apart.
// Ports: clk, reset (sync, active-high), tick, start, button -> led, busy, time_ms,
// valid, early, timeout, best_ms. Optional macro REACTION_GAME_BEST_EN builds the
// best-time register; otherwise best_ms is the constant MAX_MS.
module reaction_game_timer_fsm
  import reaction_game_pkg::*;
#(
  parameter int          MS_WIDTH     = 14,
  parameter int          MAX_MS       = 9999,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          DELAY_BITS   = 11,
  parameter logic [15:0] LFSR_SEED    = reaction_game_pkg::LFSR_SEED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                button,
  output logic                led,
  output logic                busy,
  output logic [MS_WIDTH-1:0] time_ms,
  output logic                valid,
  output logic                early,
  output logic                timeout,
  output logic [MS_WIDTH-1:0] best_ms
);

  localparam logic [MS_WIDTH-1:0] LP_MAX = MS_WIDTH'(MAX_MS);
  localparam logic [MS_WIDTH-1:0] LP_MIN = MS_WIDTH'(MIN_DELAY_MS);
  localparam logic [MS_WIDTH-1:0] LP_ONE = MS_WIDTH'(1);

  if (DELAY_BITS < 1 || DELAY_BITS > 16 ||
      (MIN_DELAY_MS + (1 << DELAY_BITS) - 1) >= (1 << MS_WIDTH) ||
      MAX_MS >= (1 << MS_WIDTH) || MAX_MS < 1) begin : g_bad_cfg
    $error("reaction_game_timer_fsm: delay or MAX_MS range does not fit MS_WIDTH");
  end

  rg_state_t           r_state, w_nxt_state;
  logic [MS_WIDTH-1:0] r_delay_cnt, w_nxt_delay;
  logic [MS_WIDTH-1:0] r_time_ms, w_nxt_time, w_time_inc;
  logic                r_valid, w_nxt_valid;
  logic                r_early, w_nxt_early;
  logic                r_timeout, w_nxt_timeout;
  logic                r_led, r_busy;
  logic [15:0]         w_lfsr;

  reaction_game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  if (DELAY_BITS < 16) begin : g_lfsr_spare
    logic w_unused_lfsr;
    assign w_unused_lfsr = ^w_lfsr[15:DELAY_BITS];
  end

  assign w_time_inc = r_time_ms + LP_ONE;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_delay   = r_delay_cnt;
    w_nxt_time    = r_time_ms;
    w_nxt_valid   = r_valid;
    w_nxt_early   = r_early;
    w_nxt_timeout = r_timeout;
    case (r_state)
      ST_IDLE, ST_RESULT: begin
        if (start) begin
          w_nxt_delay   = LP_MIN + MS_WIDTH'(w_lfsr[DELAY_BITS-1:0]);
          w_nxt_time    = '0;
          w_nxt_valid   = 1'b0;
          w_nxt_early   = 1'b0;
          w_nxt_timeout = 1'b0;
          w_nxt_state   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A press wins over a coincident tick: it is a false start either way.
        if (button) begin
          w_nxt_early = 1'b1;
          w_nxt_state = ST_RESULT;
        end else if (tick) begin
          if (r_delay_cnt <= LP_ONE) begin
            w_nxt_delay = '0;
            w_nxt_state = ST_ARMED;
          end else begin
            w_nxt_delay = r_delay_cnt - LP_ONE;
          end
        end
      end
      ST_ARMED: begin
        // The press cycle's tick is not counted: time_ms is ticks strictly before the press.
        if (button) begin
          w_nxt_valid = 1'b1;
          w_nxt_state = ST_RESULT;
        end else if (tick) begin
          w_nxt_time = w_time_inc;
          if (w_time_inc == LP_MAX) begin
            w_nxt_timeout = 1'b1;
            w_nxt_state   = ST_RESULT;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_delay_cnt <= '0;
      r_time_ms   <= '0;
      r_valid     <= 1'b0;
      r_early     <= 1'b0;
      r_timeout   <= 1'b0;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_delay_cnt <= w_nxt_delay;
      r_time_ms   <= w_nxt_time;
      r_valid     <= w_nxt_valid;
      r_early     <= w_nxt_early;
      r_timeout   <= w_nxt_timeout;
      r_led       <= (w_nxt_state == ST_ARMED);
      r_busy      <= (w_nxt_state == ST_WAIT) || (w_nxt_state == ST_ARMED);
    end
  end

`ifdef REACTION_GAME_BEST_EN
  logic [MS_WIDTH-1:0] r_best_ms;

  // Captured on the same edge that raises valid, so best_ms never lags the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_best_ms <= LP_MAX;
    end else if (r_state == ST_ARMED && w_nxt_state == ST_RESULT &&
                 w_nxt_valid && w_nxt_time < r_best_ms) begin
      r_best_ms <= w_nxt_time;
    end
  end

  assign best_ms = r_best_ms;
`else
  assign best_ms = LP_MAX;
`endif

  assign led     = r_led;
  assign busy    = r_busy;
  assign time_ms = r_time_ms;
  assign valid   = r_valid;
  assign early   = r_early;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_reaction_game_timer_fsm.sv
// tb_reaction_game_timer_fsm: randomized and directed rounds against a behavioural game model.
// Latency: inputs driven on the falling edge, outputs read one full cycle later.
// tick is a free-running one-cycle pulse every 5 cycles.
module tb_reaction_game_timer_fsm;

  localparam int MS_W = 14;
  localparam int MAX  = 20;
  localparam int MIND = 4;
  localparam int DB   = 2;

  logic            clk, reset, tick, start, button;
  logic            led, busy, valid, early, timeout;
  logic [MS_W-1:0] time_ms, best_ms;

  int          n_cmp, n_err;
  int          tcnt, g_ticks;
  int          m_best;
  logic [15:0] m_lfsr, m_start_lfsr;

  reaction_game_timer_fsm #(
    .MS_WIDTH     (MS_W),
    .MAX_MS       (MAX),
    .MIN_DELAY_MS (MIND),
    .DELAY_BITS   (DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .start   (start),
    .button  (button),
    .led     (led),
    .busy    (busy),
    .time_ms (time_ms),
    .valid   (valid),
    .early   (early),
    .timeout (timeout),
    .best_ms (best_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random source of the game: 16-bit Fibonacci register, taps 16,14,13,11, stepping every cycle.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int exp_best();
`ifdef REACTION_GAME_BEST_EN
    return m_best;
`else
    return MAX;
`endif
  endfunction

  // One cycle: drive inputs after the falling edge, return at the next falling edge.
  task automatic step(input logic s, input logic b);
    start  = s;
    button = b;
    tick   = (tcnt == 0);
    if (tick) g_ticks++;
    if (s) m_start_lfsr = m_lfsr;
    tcnt = (tcnt == 4) ? 0 : tcnt + 1;
    @(negedge clk);
  endtask

  task automatic wait_led(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0);
      if (led === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    m_best = MAX;
    n_cmp++;
    if ({led, busy, valid, early, timeout} !== 5'b00000) begin
      n_err++; $display("FAIL reset_flags: got led/busy/v/e/t=%b want 00000", {led, busy, valid, early, timeout});
    end
    n_cmp++;
    if (time_ms !== 0) begin n_err++; $display("FAIL reset_time: got %0d want 0", time_ms); end
    n_cmp++;
    if (best_ms !== MAX) begin n_err++; $display("FAIL reset_best: got %0d want %0d", best_ms, MAX); end
    reset = 1'b0;
    repeat (50) step(1'b0, 1'b0);
    n_cmp++;
    if ({led, busy, valid, early, timeout} !== 5'b00000 || time_ms !== 0) begin
      n_err++; $display("FAIL idle_state: got flags=%b time=%0d want 00000 0", {led, busy, valid, early, timeout}, time_ms);
    end
    n_cmp++;
    if (best_ms !== MAX) begin n_err++; $display("FAIL idle_best: got %0d want %0d", best_ms, MAX); end
  endtask

  // Start a round, press after k armed ticks (on a tick cycle if on_tick).
  task automatic test_press(input int k, input bit on_tick);
    int d, base, a;
    bit ok;
    step(1'b1, 1'b0);
    base = g_ticks;
    d = MIND + int'(m_start_lfsr[DB-1:0]);
    n_cmp++;
    if ({busy, led, valid, early, timeout} !== 5'b10000 || time_ms !== 0) begin
      n_err++; $display("FAIL start_state: got busy/led/v/e/t=%b time=%0d want 10000 0", {busy, led, valid, early, timeout}, time_ms);
    end
    wait_led(ok);
    n_cmp++;
    if (!ok || (g_ticks - base) != d) begin
      n_err++; $display("FAIL led_delay: got %0d ticks (rose=%0d) want %0d", g_ticks - base, ok, d);
    end
    base = g_ticks;
    a = 0;
    while (a < k) begin
      step(1'b0, 1'b0);
      a = g_ticks - base;
      n_cmp++;
      if (time_ms !== a || led !== 1'b1) begin
        n_err++; $display("FAIL live_time: got time=%0d led=%b want %0d 1", time_ms, led, a);
      end
    end
    if (on_tick) while (tcnt != 0) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    if (k < m_best) m_best = k;
    n_cmp++;
    if ({valid, led, busy, early, timeout} !== 5'b10000 || time_ms !== k) begin
      n_err++; $display("FAIL press_result: got v/led/busy/e/t=%b time=%0d want 10000 %0d", {valid, led, busy, early, timeout}, time_ms, k);
    end
    n_cmp++;
    if (best_ms !== exp_best()) begin n_err++; $display("FAIL press_best: got %0d want %0d", best_ms, exp_best()); end
    step(1'b0, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || time_ms !== k) begin
      n_err++; $display("FAIL result_hold: got valid=%b time=%0d want 1 %0d", valid, time_ms, k);
    end
  endtask

  task automatic test_early(input int w);
    step(1'b1, 1'b0);
    repeat (w) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++;
    if ({early, valid, timeout, led, busy} !== 5'b10000 || time_ms !== 0) begin
      n_err++; $display("FAIL early_result: got e/v/t/led/busy=%b time=%0d want 10000 0", {early, valid, timeout, led, busy}, time_ms);
    end
    repeat (3) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    n_cmp++;
    if (led !== 1'b0 || early !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL early_hold: got led=%b early=%b busy=%b want 0 1 0", led, early, busy);
    end
    n_cmp++;
    if (best_ms !== exp_best()) begin n_err++; $display("FAIL early_best: got %0d want %0d", best_ms, exp_best()); end
  endtask

  task automatic test_timeout();
    int base;
    bit ok;
    step(1'b1, 1'b0);
    wait_led(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL timeout_arm: got led=%b want 1", led); end
    base = g_ticks;
    for (int i = 0; i < 200 && (g_ticks - base) < MAX; i++) begin
      step(1'b0, 1'b0);
      if ((g_ticks - base) < MAX && timeout !== 1'b0) begin
        n_cmp++; n_err++; $display("FAIL timeout_early: got timeout=1 at %0d ticks want 0", g_ticks - base);
      end
    end
    n_cmp++;
    if ({timeout, valid, early, led, busy} !== 5'b10000 || time_ms !== MAX) begin
      n_err++; $display("FAIL timeout_result: got t/v/e/led/busy=%b time=%0d want 10000 %0d", {timeout, valid, early, led, busy}, time_ms, MAX);
    end
    n_cmp++;
    if (best_ms !== exp_best()) begin n_err++; $display("FAIL timeout_best: got %0d want %0d", best_ms, exp_best()); end
  endtask

  task automatic test_tick_press();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    m_best = MAX;
    test_press(5, 1'b1);
    test_press(9, 1'b0);
  endtask

  task automatic test_reset_mid();
    int d, base;
    bit ok;
    step(1'b1, 1'b0);
    base = g_ticks;
    d = MIND + int'(m_start_lfsr[DB-1:0]);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || led !== 1'b0) begin n_err++; $display("FAIL busy_start: got busy=%b led=%b want 1 0", busy, led); end
    wait_led(ok);
    n_cmp++;
    if (!ok || (g_ticks - base) != d) begin
      n_err++; $display("FAIL ignored_start_delay: got %0d ticks want %0d", g_ticks - base, d);
    end
    base = g_ticks;
    while ((g_ticks - base) < 7) step(1'b0, 1'b0);
    n_cmp++;
    if (time_ms !== 7) begin n_err++; $display("FAIL armed_time7: got %0d want 7", time_ms); end
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    m_best = MAX;
    n_cmp++;
    if ({led, busy, valid, early, timeout} !== 5'b00000 || time_ms !== 0) begin
      n_err++; $display("FAIL mid_reset: got flags=%b time=%0d want 00000 0", {led, busy, valid, early, timeout}, time_ms);
    end
    n_cmp++;
    if (best_ms !== MAX) begin n_err++; $display("FAIL mid_reset_best: got %0d want %0d", best_ms, MAX); end
    test_press(2, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 6)) step(1'b0, 1'b0);
      case ($urandom_range(0, 4))
        0, 1, 2: test_press(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        3:       test_early(int'($urandom_range(0, 12)));
        default: test_timeout();
      endcase
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; tcnt = 0; g_ticks = 0; m_best = MAX;
    reset = 1'b1; start = 1'b0; button = 1'b0; tick = 1'b0;
    @(negedge clk);
    test_reset();
    test_press(3, 1'b0);
    test_early(2);
    test_timeout();
    test_tick_press();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_game_timer_fsm.md
# reaction_game_timer_fsm

Game controller that sits directly downstream of the millisecond modulo counter. It consumes that counter's one-cycle `max` pulse as a 1 ms time base and, after a `start` request, waits a pseudo-random delay. It then lights the target LED and measures, in whole milliseconds, how long the player takes to press the button. It reports the result, a false start, or a timeout to the display/score logic.

## Interface
Parameters:
- `MS_WIDTH`, 14: width of the reaction-time and delay counters.
- `MAX_MS`, 9999: reaction-time ceiling in ms; reaching it ends the round as a timeout.
- `MIN_DELAY_MS`, 1000: fixed part of the pre-LED delay in ms.
- `DELAY_BITS`, 11: random part of the delay is `lfsr[DELAY_BITS-1:0]`, range 0..2^DELAY_BITS-1.
- `LFSR_SEED`, 16'hACE1: LFSR value at reset. Must be nonzero.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `tick`, input, 1: 1 ms pulse from the upstream counter's `max`, one cycle wide.
- `start`, input, 1: round request pulse.
- `button`, input, 1: player button, already synchronized and debounced; 1 means pressed.
- `led`, output, 1: target LED; high only in ARMED.
- `busy`, output, 1: high in WAIT and ARMED.
- `time_ms`, output, MS_WIDTH: reaction time; counts live in ARMED and holds afterwards.
- `valid`, output, 1: a legal reaction result is held on `time_ms`.
- `early`, output, 1: false start, meaning the button was pressed during WAIT.
- `timeout`, output, 1: no press before `MAX_MS`.
- `best_ms`, output, MS_WIDTH: best valid time since reset. See Configuration.

## Operation
- States: IDLE, WAIT, ARMED, RESULT. Encoded as an enum.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle regardless of state, which keeps the delay dependent on player timing.
- IDLE or RESULT, `start`=1: load `delay_cnt = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0]`, zero `time_ms`, clear `valid`/`early`/`timeout`, then go to WAIT. `start` is ignored in WAIT and ARMED.
- WAIT:
  - `button`=1: set `early`=1 and go to RESULT.
  - Else on `tick`: decrement `delay_cnt`. If the decrement takes it from 1 to 0, go to ARMED.
  - `button` has priority over `tick` in the same cycle.
- ARMED:
  - `button`=1: set `valid`=1 and go to RESULT. `time_ms` is not incremented in that cycle, even if `tick`=1.
  - Else on `tick`: increment `time_ms`. If the new value equals `MAX_MS`, set `timeout`=1 and go to RESULT with `valid`=0.
- RESULT: all flags and `time_ms` hold until the next `start` or `reset`.
- Arithmetic: unsigned. `MIN_DELAY_MS + 2^DELAY_BITS - 1` and `MAX_MS` must fit in MS_WIDTH (elaboration check). No wrap is ever reached.
- `reset` mid-round: abort immediately to IDLE. The LFSR reloads its seed.

## Timing
- All outputs are registered. Reset values: `led`=0, `busy`=0, `time_ms`=0, `valid`=0, `early`=0, `timeout`=0, `best_ms`=`MAX_MS`, state IDLE.
- `start` in cycle N: `busy`=1 and flags cleared at N+1.
- Delay: LED rises on the cycle after the (MIN_DELAY_MS+r)-th `tick` following the start.
- Press sampled in cycle M: `led`=0, `busy`=0, and `valid`/`early` are 1 at M+1.
- `time_ms` equals the number of `tick` pulses seen in ARMED before the press cycle (0 is legal).
- `tick` is assumed to be at least 2 cycles apart; no other handshake exists.

## Configuration
- `REACTION_GAME_BEST_EN` defined:
  - `best_ms` register, reset to `MAX_MS`.
  - On each transition to RESULT with `valid`=1 and `time_ms < best_ms`, `best_ms` takes `time_ms` on the same edge as `valid`.
- Not defined: `best_ms` is driven constant `MAX_MS` and no register is built. The port list is unchanged.

## Structure
- Shared package `reaction_game_pkg`: state enum `rg_state_t`, `LFSR_TAPS`, and the default `LFSR_SEED`.
- One sub-module, `reaction_game_lfsr` (16-bit, enable tied high, seed parameter). It is reused by later random-pattern blocks.

## Test plan
Bench settings: `MIN_DELAY_MS`=4, `DELAY_BITS`=2, `MAX_MS`=20, `tick` every 5 cycles.
- Reset, then idle for 50 cycles: all outputs at reset values, `best_ms`=20.
- `start`, press 3 ticks after `led` rises: `led` rose after 4..7 ticks; `valid`=1, `time_ms`=3, `best_ms`=3 (macro on).
- `start`, hold `button` in WAIT: `early`=1, `led` never rises, `time_ms`=0, `valid`=0.
- `start`, never press: `timeout`=1 with `time_ms`=20 one cycle after the 20th armed tick; `valid`=0; `best_ms` unchanged.
- `button` and `tick` in the same ARMED cycle at `time_ms`=5: result `time_ms`=5. Second round pressed at 9: `best_ms` stays 5.
- `reset` asserted in ARMED at `time_ms`=7: next cycle IDLE, `led`=0, `time_ms`=0. `start` pulse while `busy`=1 is ignored.
